// File: rtl/crc8_pkg.sv
// Shared types and constants for the bit-serial CRC-8 engine.
package crc8_pkg;

   localparam int unsigned CRC_W = 8;
   localparam int unsigned CNT_W = 16;

   localparam logic [CRC_W-1:0] POLY_DEF   = 8'h07;
   localparam logic [CRC_W-1:0] INIT_DEF   = 8'h00;
   localparam logic [CRC_W-1:0] XOROUT_DEF = 8'h55;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // Bit counter increment that sticks at the all-ones value.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
   endfunction

endpackage

// File: rtl/crc8_step.sv
// One-bit CRC-8 update: MSB-first feedback into a shifted register,
// built entirely from 2-input XOR cells.
module crc8_step
   import crc8_pkg::*;
(
   input  logic [CRC_W-1:0] i_crc,
   input  logic             i_bit,
   input  logic [CRC_W-1:0] i_poly,
   output logic [CRC_W-1:0] o_crc
);

   logic             w_fb;
   logic [CRC_W-1:0] w_shift;
   logic [CRC_W-1:0] w_mask;

   xor u_fb (w_fb, i_bit, i_crc[CRC_W-1]);

   assign w_shift = {i_crc[CRC_W-2:0], 1'b0};
   assign w_mask  = i_poly & {CRC_W{w_fb}};

   for (genvar g = 0; g < CRC_W; g++) begin : g_bit
      xor u_x (o_crc[g], w_shift[g], w_mask[g]);
   end

endmodule

// File: rtl/crc8_serial_engine.sv
// Bit-serial CRC-8 generator with valid/ready on both sides, one frame in
// flight. Optional macro CRC_XOROUT_EN applies the XOROUT mask to out_crc.
module crc8_serial_engine
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY   = POLY_DEF,
   parameter logic [7:0] INIT   = INIT_DEF,
   parameter logic [7:0] XOROUT = XOROUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_bit,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_crc,
   output logic [15:0] out_bits
);

`ifdef CRC_XOROUT_EN
   localparam logic [7:0] OUT_MASK = XOROUT;
`else
   // Plain CRC-8: mask collapses to zero, XOROUT only referenced here.
   localparam logic [7:0] OUT_MASK = XOROUT & 8'h00;
`endif

   state_t           r_state;
   state_t           w_state_d;
   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] w_crc_d;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic [CRC_W-1:0] r_out_crc;
   logic [CNT_W-1:0] r_out_bits;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             w_in_ready_d;
   logic             w_out_valid_d;
   logic             w_accept;
   logic             w_release;
   logic             w_done_entry;

   assign w_accept     = in_valid & r_in_ready;
   assign w_release    = r_out_valid & out_ready;
   assign w_done_entry = w_accept & in_last;
   assign w_cnt_d      = cnt_inc(r_cnt);

   crc8_step u_step (
      .i_crc  (r_crc),
      .i_bit  (in_bit),
      .i_poly (POLY),
      .o_crc  (w_crc_d)
   );

   // Next-state and registered-output targets; handshake flags derive from next state only.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         IDLE, SHIFT: begin
            if (w_accept) begin
               w_state_d = in_last ? DONE : SHIFT;
            end
         end
         DONE: begin
            if (w_release) begin
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
      w_in_ready_d  = (w_state_d != DONE);
      w_out_valid_d = (w_state_d == DONE);
   end

   // State register and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_in_ready  <= w_in_ready_d;
         r_out_valid <= w_out_valid_d;
      end
   end

   // CRC shift register and bit counter; reloaded when the result is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc <= INIT;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_crc <= w_crc_d;
         r_cnt <= w_cnt_d;
      end else if (w_release) begin
         r_crc <= INIT;
         r_cnt <= '0;
      end
   end

   // Result registers, captured only on the edge that enters DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_crc  <= '0;
         r_out_bits <= '0;
      end else if (w_done_entry) begin
         r_out_crc  <= w_crc_d ^ OUT_MASK;
         r_out_bits <= w_cnt_d;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_crc   = r_out_crc;
   assign out_bits  = r_out_bits;

endmodule

// File: tb/tb_crc8_serial_engine.sv
// Self-checking bench for crc8_serial_engine: directed vectors plus random
// frames checked against a polynomial-division reference model.
module tb_crc8_serial_engine;

`ifdef CRC_XOROUT_EN
   localparam logic [7:0] MASK = 8'h55;
`else
   localparam logic [7:0] MASK = 8'h00;
`endif

   typedef struct {
      logic [7:0]  crc;
      logic [15:0] bits;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_bit;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_crc;
   logic [15:0] out_bits;

   int   n_vec = 0;
   int   n_err = 0;
   int   n_pushed = 0;
   int   n_results = 0;
   bit   tx_bits[$];
   exp_t exp_q[$];

   bit          prev_hold = 1'b0;
   logic [7:0]  prev_crc;
   logic [15:0] prev_bits;

   crc8_serial_engine dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_crc   (out_crc),
      .out_bits  (out_bits)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: remainder of M(x)*x^8 divided by x^8+x^2+x+1 (INIT is zero).
   function automatic logic [7:0] ref_crc();
      logic [8:0] r = '0;
      foreach (tx_bits[i]) begin
         r = {r[7:0], tx_bits[i]};
         if (r[8]) r = r ^ 9'h107;
      end
      for (int i = 0; i < 8; i++) begin
         r = {r[7:0], 1'b0};
         if (r[8]) r = r ^ 9'h107;
      end
      return r[7:0] ^ MASK;
   endfunction

   task automatic load_byte(input logic [7:0] b);
      tx_bits.delete();
      for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
   endtask

   task automatic load_check_string();
      logic [7:0] s [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      tx_bits.delete();
      for (int k = 0; k < 9; k++)
         for (int i = 7; i >= 0; i--) tx_bits.push_back(s[k][i]);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_bit   = 1'bx;
      in_last  = 1'b0;
   endtask

   // Drives tx_bits as one frame; leaves in_valid asserted on return.
   task automatic send_frame(input int gap_max, input logic [7:0] exp_crc, input bit use_exp,
                             output int stall0);
      exp_t e;
      int   n;
      int   stall;
      n      = tx_bits.size();
      e.crc  = use_exp ? (exp_crc ^ MASK) : ref_crc();
      e.bits = (n > 65535) ? 16'hFFFF : 16'(n);
      exp_q.push_back(e);
      n_pushed++;
      stall0 = 0;
      for (int i = 0; i < n; i++) begin
         if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
               idle();
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_bit   = tx_bits[i];
         in_last  = (i == n - 1);
         stall    = 0;
         while (!in_ready) begin
            stall++;
            if (stall > 1000) begin
               chk("in_ready_timeout", 0, 1);
               return;
            end
            @(posedge clk); #1;
         end
         if (i == 0) stall0 = stall;
         @(posedge clk); #1;
      end
   endtask

   // Result monitor: checks handshake, hold stability, and values against the model.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (out_valid) begin
            chk("in_ready_in_done", in_ready, 0);
            if (prev_hold) begin
               chk("crc_hold", out_crc, prev_crc);
               chk("bits_hold", out_bits, prev_bits);
            end
            if (out_ready) begin
               n_results++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", 1, 0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("out_crc", out_crc, e.crc);
                  chk("out_bits", out_bits, e.bits);
               end
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_crc  = out_crc;
         prev_bits = out_bits;
      end
   end

   initial begin
      int s;
      rst = 1'b1;
      out_ready = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_crc", out_crc, 0);
      chk("rst_out_bits", out_bits, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Byte 00: result valid for exactly one cycle with out_ready high.
      load_byte(8'h00);
      send_frame(0, 8'h00, 1, s);
      idle();
      chk("ov_first_cycle", out_valid, 1);
      @(posedge clk); #1;
      chk("ov_one_cycle", out_valid, 0);

      // Back-to-back 01 then FF: exactly one bubble between frames.
      load_byte(8'h01);
      send_frame(0, 8'h07, 1, s);
      load_byte(8'hFF);
      send_frame(0, 8'hF3, 1, s);
      chk("bubble", s, 1);
      idle();
      @(posedge clk); #1;

      // Check string.
      load_check_string();
      send_frame(0, 8'hF4, 1, s);
      idle();
      @(posedge clk); #1;

      // Random gaps with output stalled; input ignored while DONE.
      tx_bits.delete();
      repeat (24) tx_bits.push_back(1'($urandom));
      out_ready = 1'b0;
      send_frame(3, 8'h00, 0, s);
      repeat (5) begin
         in_valid = 1'b1;
         in_bit   = 1'($urandom);
         in_last  = 1'($urandom);
         @(posedge clk); #1;
         chk("done_ignores_in", in_ready, 0);
      end
      idle();
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("ov_drop_after_hs", out_valid, 0);
      send_frame(0, 8'h00, 0, s);
      idle();
      @(posedge clk); #1;

      // Abort after 4 bits.
      repeat (4) begin
         in_valid = 1'b1;
         in_bit   = 1'($urandom);
         in_last  = 1'b0;
         @(posedge clk); #1;
      end
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_crc", out_crc, 0);
      chk("abort_out_bits", out_bits, 0);
      rst = 1'b0;
      load_check_string();
      send_frame(0, 8'hF4, 1, s);
      idle();
      @(posedge clk); #1;

      // Single-bit frame.
      tx_bits.delete();
      tx_bits.push_back(1'b1);
      send_frame(0, 8'h07, 1, s);
      idle();
      @(posedge clk); #1;

      // Random frames with random gaps.
      repeat (6) begin
         int len;
         len = $urandom_range(1, 40);
         tx_bits.delete();
         repeat (len) tx_bits.push_back(1'($urandom));
         send_frame(2, 8'h00, 0, s);
         idle();
         @(posedge clk); #1;
      end

      // Counter saturation.
      tx_bits.delete();
      repeat (70000) tx_bits.push_back(1'b0);
      send_frame(0, 8'h00, 1, s);
      idle();

      repeat (3) @(posedge clk);
      #1;
      chk("results_outstanding", exp_q.size(), 0);
      chk("results_seen", n_results, n_pushed);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
